fp_align_add_seq: RTL



---
 rtl/fp_align_add_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fp_align_add_seq.sv
// Sequential mantissa alignment and add/subtract stage of the floating-point adder.
// The smaller operand is shifted right over several cycles; normalisation and rounding happen downstream.
module fp_align_add_seq #(
   parameter int EXP_W           = 8,
   parameter int MAN_W           = 24,
   parameter int SHIFT_PER_CYCLE = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Load,
   output logic             Ready,
   input  logic             S_A,
   input  logic             S_B,
   input  logic [EXP_W-1:0] E_A,
   input  logic [EXP_W-1:0] E_B,
   input  logic [MAN_W-1:0] M_A,
   input  logic [MAN_W-1:0] M_B,
   output logic             S_Result,
   output logic [EXP_W-1:0] E_Result,
   output logic [MAN_W-1:0] M_Result,
   output logic             Guard,
   output logic             Round_bit,
   output logic             Sticky,
   output logic             Carry,
   output logic             Zero,
   output logic             Busy,
   output logic             Result_valid,
   input  logic             Result_ack,
   output logic [1:0]       state_dbg
);

   // Handshakes: an operand is taken on an edge with Load=1 and Ready=1; a result is
   // offered while Result_valid=1 and released on an edge with Result_ack=1.

   localparam int EXT_W = MAN_W + 3;
   localparam int CW    = $clog2(EXT_W + 1);
   localparam logic [CW-1:0] SPC_C = CW'(SHIFT_PER_CYCLE);
   localparam logic [CW-1:0] MAX_C = CW'(EXT_W);

   typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

   state_t state_r, state_nx;

   logic             big_s_r, sa_r, op_r, sticky_r;
   logic [EXP_W-1:0] big_e_r;
   logic [EXT_W-1:0] big_m_r, small_r;
   logic [CW-1:0]    rem_r;

   // Capture-time ordering and shift distance
   logic             a_big;
   logic [EXP_W-1:0] d;
   logic [31:0]      d32;
   logic [CW-1:0]    dsat;

   always_comb begin
      a_big = (E_A > E_B) || ((E_A == E_B) && (M_A >= M_B));
      d     = a_big ? (E_A - E_B) : (E_B - E_A);
      d32   = 32'(d);
      dsat  = (d32 > 32'(EXT_W)) ? MAX_C : CW'(d32);
   end

   // One alignment step: shifted value plus OR of the bits falling off the LSB
   logic [CW-1:0]    amt;
   logic [EXT_W-1:0] small_sh;
   logic             lost;

   always_comb begin
      amt      = (rem_r > SPC_C) ? SPC_C : rem_r;
      small_sh = small_r >> amt;
      lost     = |(small_r & ~({EXT_W{1'b1}} << amt));
   end

   // Add/subtract on magnitude-ordered operands; sticky is folded into the LSB only here
   logic [EXT_W-1:0] small_fin, diff;
   logic [EXT_W:0]   sum;

   always_comb begin
      small_fin = small_r | {{(EXT_W-1){1'b0}}, sticky_r};
      sum       = {1'b0, big_m_r} + {1'b0, small_fin};
      diff      = big_m_r - small_fin;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state_r <= IDLE;
      else       state_r <= state_nx;
   end

   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE:    if (Load) state_nx = (dsat != '0) ? ALIGN : ADD;
         ALIGN:   if (rem_r <= SPC_C) state_nx = ADD;
         ADD:     state_nx = DONE;
         DONE:    if (Result_ack) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      Ready        = (state_r == IDLE);
      Busy         = (state_r != IDLE);
      Result_valid = (state_r == DONE);
      state_dbg    = state_r;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         big_s_r   <= 1'b0;
         sa_r      <= 1'b0;
         op_r      <= 1'b0;
         sticky_r  <= 1'b0;
         big_e_r   <= '0;
         big_m_r   <= '0;
         small_r   <= '0;
         rem_r     <= '0;
         S_Result  <= 1'b0;
         E_Result  <= '0;
         M_Result  <= '0;
         Guard     <= 1'b0;
         Round_bit <= 1'b0;
         Sticky    <= 1'b0;
         Carry     <= 1'b0;
         Zero      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (Load) begin
                  sa_r     <= S_A;
                  op_r     <= S_A ^ S_B;
                  big_s_r  <= a_big ? S_A : S_B;
                  big_e_r  <= a_big ? E_A : E_B;
                  big_m_r  <= {(a_big ? M_A : M_B), 3'b000};
                  small_r  <= {(a_big ? M_B : M_A), 3'b000};
                  sticky_r <= 1'b0;
                  rem_r    <= dsat;
               end
            end
            ALIGN: begin
               small_r  <= small_sh;
               sticky_r <= sticky_r | lost;
               rem_r    <= rem_r - amt;
            end
            ADD: begin
               E_Result <= big_e_r;
               if (!op_r) begin
                  {Carry, M_Result, Guard, Round_bit, Sticky} <= sum;
                  S_Result <= sa_r;
                  Zero     <= (sum == '0);
               end else begin
                  Carry    <= 1'b0;
                  {M_Result, Guard, Round_bit, Sticky} <= diff;
                  // Exact cancellation yields +0
                  S_Result <= (diff == '0) ? 1'b0 : big_s_r;
                  Zero     <= (diff == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
